// File: rtl/snake_move_ctrl.sv
// Snake movement scheduler: button debounce, pending direction with reversal
// rejection, step tick generation, head advance with wrap, IDLE/RUN/DEAD FSM.

module snake_btn_deb #(
   parameter int DEB_CNT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);
   localparam int CW = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT);

   logic          s1, s2, lvl, lvl_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         lvl   <= 1'b1;
         lvl_d <= 1'b1;
         cnt   <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         lvl_d <= lvl;
         if (s2 == lvl) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CNT - 1)) begin
            lvl <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // one-cycle pulse on the released->pressed edge of the debounced level
   assign press = lvl_d & ~lvl;
endmodule

module snake_move_ctrl #(
   parameter int TICK_DIV = 2500000,
   parameter int DEB_CNT  = 250000,
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       btn3,
   input  logic       btn4,
   input  logic       collision,
   output logic [1:0] move_direction,
   output logic [5:0] head_x,
   output logic [4:0] head_y,
   output logic       step,
   output logic       running,
   output logic       dead
);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [5:0] X0 = 6'(GRID_W / 2);
   localparam logic [4:0] Y0 = 5'(GRID_H / 2);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   state_t        state;
   logic [TW-1:0] tcnt;
   logic [1:0]    pending_dir, pdir, ref_dir;
   logic [3:0]    raw, press;
   logic          any_press, tick_due, tick, accept;
   logic [5:0]    nx;
   logic [4:0]    ny;

   assign raw = {btn4, btn3, btn2, btn1};

   for (genvar i = 0; i < 4; i++) begin : g_deb
      snake_btn_deb #(.DEB_CNT(DEB_CNT)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (raw[i]),
         .press (press[i])
      );
   end

   always_comb begin
      any_press = |press;
      pdir = 2'd3;
      if (press[0])      pdir = 2'd0;
      else if (press[1]) pdir = 2'd1;
      else if (press[2]) pdir = 2'd2;
      tick_due = (state == RUN) && (tcnt == TW'(TICK_DIV - 1));
      tick     = tick_due && !collision;
      // on a tick edge the pending direction is what gets committed
      ref_dir  = tick_due ? pending_dir : move_direction;
      accept   = any_press && (pdir != (ref_dir ^ 2'd2));
      nx = head_x;
      ny = head_y;
      case (pending_dir)
         2'd0: nx = (head_x == 6'd0) ? 6'(GRID_W - 1) : head_x - 6'd1;
         2'd1: ny = (head_y == 5'd0) ? 5'(GRID_H - 1) : head_y - 5'd1;
         2'd2: nx = (head_x == 6'(GRID_W - 1)) ? 6'd0 : head_x + 6'd1;
         default: ny = (head_y == 5'(GRID_H - 1)) ? 5'd0 : head_y + 5'd1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         tcnt           <= '0;
         move_direction <= 2'd2;
         pending_dir    <= 2'd2;
         head_x         <= X0;
         head_y         <= Y0;
         step           <= 1'b0;
         running        <= 1'b0;
         dead           <= 1'b0;
      end else begin
         step <= 1'b0;
         case (state)
            IDLE: begin
               tcnt <= '0;
               if (accept) begin
                  pending_dir <= pdir;
                  state       <= RUN;
                  running     <= 1'b1;
               end
            end
            RUN: begin
               if (collision) begin
                  state   <= DEAD;
                  running <= 1'b0;
                  dead    <= 1'b1;
               end else begin
                  tcnt <= tick ? '0 : tcnt + 1'b1;
                  if (accept) pending_dir <= pdir;
                  if (tick) begin
                     move_direction <= pending_dir;
                     head_x         <= nx;
                     head_y         <= ny;
                     step           <= 1'b1;
                  end
               end
            end
            DEAD: begin
               // restart press is consumed; it does not seed pending_dir
               if (any_press) begin
                  state          <= IDLE;
                  tcnt           <= '0;
                  move_direction <= 2'd2;
                  pending_dir    <= 2'd2;
                  head_x         <= X0;
                  head_y         <= Y0;
                  running        <= 1'b0;
                  dead           <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboarded bench for snake_move_ctrl with TICK_DIV=16, DEB_CNT=4.

module tb_snake_move_ctrl;
   typedef struct {
      logic [1:0] d;
      int         x;
      int         y;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] btn;
   logic       collision;
   logic [1:0] move_direction;
   logic [5:0] head_x;
   logic [4:0] head_y;
   logic       step, running, dead;

   exp_t exp_q[$];
   int   total = 0, bad = 0;
   int   cyc = 0, nsteps = 0, last_step = -1, epoch = 0, last_epoch = 0;
   int   mx = 20, my = 15;

   snake_move_ctrl #(.TICK_DIV(16), .DEB_CNT(4), .GRID_W(40), .GRID_H(30)) dut (
      .clk            (clk),
      .reset          (reset),
      .btn1           (btn[0]),
      .btn2           (btn[1]),
      .btn3           (btn[2]),
      .btn4           (btn[3]),
      .collision      (collision),
      .move_direction (move_direction),
      .head_x         (head_x),
      .head_y         (head_y),
      .step           (step),
      .running        (running),
      .dead           (dead)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // expected head after n steps in direction d, with grid wrap
   task automatic exp_move(input logic [1:0] d, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         case (d)
            2'd0: mx = (mx == 0) ? 39 : mx - 1;
            2'd1: my = (my == 0) ? 29 : my - 1;
            2'd2: mx = (mx == 39) ? 0 : mx + 1;
            default: my = (my == 29) ? 0 : my + 1;
         endcase
         e.d = d; e.x = mx; e.y = my;
         exp_q.push_back(e);
      end
   endtask

   task automatic press(input logic [3:0] m);
      btn = btn & ~m;
      repeat (10) @(negedge clk);
      btn = btn | m;
   endtask

   task automatic wait_steps(input int n);
      int target;
      bit hit;
      target = nsteps + n;
      hit = 0;
      for (int i = 0; i < n * 16 + 40; i++) begin
         @(negedge clk);
         #1;
         if (nsteps >= target) begin
            hit = 1;
            break;
         end
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL step_timeout: got %0d steps expected %0d", nsteps, target);
      end
   endtask

   initial begin
      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (reset && step) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_step: got dir=%0d x=%0d y=%0d expected no step",
                           move_direction, head_x, head_y);
               end else begin
                  e = exp_q.pop_front();
                  if (move_direction !== e.d || int'(head_x) != e.x || int'(head_y) != e.y) begin
                     bad++;
                     $display("FAIL step_value: got dir=%0d x=%0d y=%0d expected dir=%0d x=%0d y=%0d",
                              move_direction, head_x, head_y, e.d, e.x, e.y);
                  end
               end
               if (last_step >= 0 && last_epoch == epoch) begin
                  total++;
                  if (cyc - last_step != 16) begin
                     bad++;
                     $display("FAIL step_gap: got %0d expected 16", cyc - last_step);
                  end
               end
               last_step  = cyc;
               last_epoch = epoch;
               nsteps++;
            end
         end
      join_none

      // reset, buttons ignored while held
      reset = 1'b0; btn = 4'b1110; collision = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_dir", move_direction, 2);
      chk("rst_x", head_x, 20);
      chk("rst_y", head_y, 15);
      chk("rst_step", step, 0);
      chk("rst_running", running, 0);
      chk("rst_dead", dead, 0);
      btn = 4'hf;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_after_rst", running, 0);

      // left is a reversal of the reset direction: stays IDLE
      press(4'b0001);
      repeat (10) @(negedge clk);
      chk("idle_reject_left", running, 0);

      // start moving down
      exp_move(2'd3, 2);
      press(4'b1000);
      chk("start_running", running, 1);
      wait_steps(2);
      chk("down_y17", head_y, 17);

      // turn right, reject left, then up-then-left within one tick
      exp_move(2'd2, 1);
      press(4'b0100);
      wait_steps(1);
      exp_move(2'd2, 1);
      press(4'b0001);
      wait_steps(1);
      chk("rev_left_rejected", move_direction, 2);
      exp_move(2'd1, 1);
      btn[1] = 1'b0;
      repeat (2) @(negedge clk);
      btn[0] = 1'b0;
      repeat (8) @(negedge clk);
      btn[1] = 1'b1;
      repeat (2) @(negedge clk);
      btn[0] = 1'b1;
      wait_steps(1);
      chk("up_accepted", move_direction, 1);
      chk("up_y16", head_y, 16);

      // wrap up through y=0, then right through x=39
      exp_move(2'd1, 17);
      wait_steps(17);
      chk("wrap_up_y29", head_y, 29);
      exp_move(2'd2, 18);
      press(4'b0100);
      wait_steps(18);
      chk("wrap_right_x0", head_x, 0);

      // collision on the tick cycle suppresses the step
      repeat (15) @(negedge clk);
      collision = 1'b1;
      @(negedge clk);
      collision = 1'b0;
      epoch++;
      chk("col_dead", dead, 1);
      chk("col_running", running, 0);
      chk("col_step", step, 0);
      chk("col_x", head_x, 0);
      repeat (20) @(negedge clk);
      chk("dead_hold", dead, 1);
      chk("dead_y_frozen", head_y, 29);
      press(4'b0100);
      repeat (5) @(negedge clk);
      chk("restart_dead", dead, 0);
      chk("restart_running", running, 0);
      chk("restart_dir", move_direction, 2);
      chk("restart_x", head_x, 20);
      chk("restart_y", head_y, 15);
      mx = 20; my = 15;
      repeat (30) @(negedge clk);

      // simultaneous press while moving down: btn1 wins
      exp_move(2'd3, 1);
      press(4'b1000);
      wait_steps(1);
      exp_move(2'd0, 1);
      press(4'b0011);
      wait_steps(1);
      chk("simul_dir_left", move_direction, 0);
      chk("simul_x19", head_x, 19);

      // asynchronous reset mid-RUN
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      epoch++;
      chk("arst_dir", move_direction, 2);
      chk("arst_x", head_x, 20);
      chk("arst_y", head_y, 15);
      chk("arst_running", running, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst_idle", running, 0);
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
